// File: rtl/shift_unit_pipe_if.sv
// Valid/ready bundle for the pipelined shifter: operation request in, shifted result out.
// The bench drives the master side and the shifter implements the slave side.
interface shift_unit_pipe_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 4
);
  localparam int unsigned AW = $clog2(XLEN);

  logic            In_Valid;
  logic            In_Ready;
  logic [XLEN-1:0] Src1;
  logic [AW-1:0]   Src2;
  logic [2:0]      Op;
  logic [TAGW-1:0] Tag;
  logic            Flush;
  logic            Out_Valid;
  logic            Out_Ready;
  logic [XLEN-1:0] Result;
  logic [TAGW-1:0] Out_Tag;
  logic            Illegal;

  modport master (
    output In_Valid, Src1, Src2, Op, Tag, Flush, Out_Ready,
    input  In_Ready, Out_Valid, Result, Out_Tag, Illegal
  );

  modport slave (
    input  In_Valid, Src1, Src2, Op, Tag, Flush, Out_Ready,
    output In_Ready, Out_Valid, Result, Out_Tag, Illegal
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready flow control, flush and tag sideband.
// The log2(XLEN) barrel levels are spread across STAGES register stages in order.
module shift_unit_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAGW   = 4
) (
  input logic              CLK,
  input logic              rst_n,
  shift_unit_pipe_if.slave bus
);

  localparam int unsigned AW  = $clog2(XLEN);
  localparam int          LPS = int'((AW + STAGES - 1) / STAGES);
  localparam int          NST = int'(STAGES);
  localparam int          NLV = int'(AW);

  localparam logic [2:0] OpSll = 3'b000;
  localparam logic [2:0] OpSrl = 3'b001;
  localparam logic [2:0] OpSra = 3'b011;
  localparam logic [2:0] OpRol = 3'b100;
  localparam logic [2:0] OpRor = 3'b101;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] ill_q;
  logic [STAGES-1:0] sgn_q;
  logic [XLEN-1:0]   data_q [STAGES];
  logic [AW-1:0]     amt_q  [STAGES];
  logic [2:0]        op_q   [STAGES];
  logic [TAGW-1:0]   tag_q  [STAGES];

  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] src_ill;
  logic [STAGES-1:0] src_sgn;
  logic [XLEN-1:0]   src_data [STAGES];
  logic [AW-1:0]     src_amt  [STAGES];
  logic [2:0]        src_op   [STAGES];
  logic [TAGW-1:0]   src_tag  [STAGES];
  logic [XLEN-1:0]   data_d   [STAGES];

  logic [STAGES-1:0] adv;
  logic              full;
  logic              in_ready;
  logic              in_legal;

  // One barrel level by a constant distance; unknown ops pass data through (already zero).
  function automatic logic [XLEN-1:0] apply_level(input logic [XLEN-1:0] d,
                                                  input logic [2:0]      op,
                                                  input logic            sgn,
                                                  input int unsigned     sh);
    logic [XLEN-1:0] fill;
    fill = sgn ? ~({XLEN{1'b1}} >> sh) : '0;
    case (op)
      OpSll:   return d << sh;
      OpSrl:   return d >> sh;
      OpSra:   return (d >> sh) | fill;
      OpRol:   return (d << sh) | (d >> (XLEN - sh));
      OpRor:   return (d >> sh) | (d << (XLEN - sh));
      default: return d;
    endcase
  endfunction

  assign in_legal = (bus.Op == OpSll) || (bus.Op == OpSrl) || (bus.Op == OpSra) ||
                    (bus.Op == OpRol) || (bus.Op == OpRor);

  // Stage k may move only if some stage at or after it is empty, or the output retires.
  always_comb begin
    adv  = '0;
    full = 1'b1;
    for (int k = NST - 1; k >= 0; k--) begin
      full   = full & vld_q[k];
      adv[k] = ~(full & ~bus.Out_Ready);
    end
  end

  assign in_ready = adv[0] & rst_n & ~bus.Flush;

  always_comb begin
    src_vld     = '0;
    src_ill     = '0;
    src_sgn     = '0;
    src_vld[0]  = bus.In_Valid & in_ready;
    src_ill[0]  = ~in_legal;
    src_sgn[0]  = in_legal & bus.Src1[XLEN-1];
    src_data[0] = in_legal ? bus.Src1 : '0;
    src_amt[0]  = bus.Src2;
    src_op[0]   = bus.Op;
    src_tag[0]  = bus.Tag;
    for (int k = 1; k < NST; k++) begin
      src_vld[k]  = vld_q[k-1];
      src_ill[k]  = ill_q[k-1];
      src_sgn[k]  = sgn_q[k-1];
      src_data[k] = data_q[k-1];
      src_amt[k]  = amt_q[k-1];
      src_op[k]   = op_q[k-1];
      src_tag[k]  = tag_q[k-1];
    end
  end

  // The last stage absorbs any levels left over by the per-stage split.
  always_comb begin
    for (int k = 0; k < NST; k++) begin
      data_d[k] = src_data[k];
      for (int j = 0; j < NLV; j++) begin
        if ((j >= k * LPS) && ((j < (k + 1) * LPS) || (k == NST - 1)) && src_amt[k][j]) begin
          data_d[k] = apply_level(data_d[k], src_op[k], src_sgn[k], 32'(1) << j);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      vld_q <= '0;
      ill_q <= '0;
      sgn_q <= '0;
      for (int k = 0; k < NST; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        op_q[k]   <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NST; k++) begin
        if (bus.Flush) begin
          vld_q[k] <= 1'b0;
        end else if (adv[k]) begin
          vld_q[k] <= src_vld[k];
        end
        // Payload loads only with a real operation so an idle output keeps its last value.
        if (adv[k] && src_vld[k]) begin
          data_q[k] <= data_d[k];
          amt_q[k]  <= src_amt[k];
          op_q[k]   <= src_op[k];
          tag_q[k]  <= src_tag[k];
          ill_q[k]  <= src_ill[k];
          sgn_q[k]  <= src_sgn[k];
        end
      end
    end
  end

  assign bus.In_Ready  = in_ready;
  assign bus.Out_Valid = vld_q[STAGES-1];
  assign bus.Result    = data_q[STAGES-1];
  assign bus.Out_Tag   = tag_q[STAGES-1];
  assign bus.Illegal   = ill_q[STAGES-1];

endmodule
